// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the RV32I decode stage.
//   - XLEN, opcode constants, ALUControl and ResultSrc codes
//   - imm_src_e: immediate format selector (I/S/B/J/U)
//   - ctrl_t: the control bundle carried into execute
//   - alu_fn / extend_imm: helpers used by decode_stage
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    // funct3 -> ALU op. sub_ok is only set for R-type, so addi with a
    // stray bit 30 in its immediate never turns into a subtract.
    function automatic logic [2:0] alu_fn(logic [2:0] funct3, logic sub_ok);
        case (funct3)
            3'b000:  alu_fn = sub_ok ? ALU_SUB : ALU_ADD;
            3'b010:  alu_fn = ALU_SLT;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: alu_fn = ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] extend_imm(logic [31:0] instr, imm_src_e src);
        case (src)
            IMM_S:   extend_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   extend_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   extend_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   extend_imm = {instr[31:12], 12'b0};
            default: extend_imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: all non-clock/reset signals of the decode stage.
//   master (fetch/hazard/writeback/execute side): drives InstrD, PCD,
//     PCPlus4D, FlushE, RegWriteW, RdW, ResultW; receives Rs1D/Rs2D and
//     the registered E-stage outputs.
//   slave (decode_stage): the mirror image.
interface decode_stage_if #(parameter int XLEN = 32);
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            FlushE;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;

    logic [4:0]      Rs1D, Rs2D;
    logic            RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]      Rs1E, Rs2E, RdE;

    modport master (
        output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
        input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        input  ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
        input  Rs1E, Rs2E, RdE
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
        output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        output ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
        output Rs1E, Rs2E, RdE
    );
endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32 x XLEN register file, two async read ports, one write.
//   clk, rst         : clock, synchronous active-high reset (x1..x31 <- RESET_VAL)
//   ra1_i/ra2_i      : read indices; rd1_o/rd2_o read data (x0 reads 0)
//   we_i/wa_i/wd_i   : write enable/index/data, committed on rising edge;
//                      writes to x0 are dropped
// Optional macro RF_WRITE_BYPASS_EN: a read of the register being written
// this cycle returns wd_i instead of the stored value.
module regfile_2r1w #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);
    // x0 has no storage
    logic [XLEN-1:0] regs_q [31:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) regs_q[i] <= RESET_VAL;
        end else if (we_i && wa_i != 5'd0) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
        rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];
`ifdef RF_WRITE_BYPASS_EN
        if (we_i && wa_i != 5'd0 && wa_i == ra1_i) rd1_o = wd_i;
        if (we_i && wa_i != 5'd0 && wa_i == ra2_i) rd2_o = wd_i;
`endif
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage plus the D/E pipeline register.
//   clk, rst : clock, synchronous active-high reset (clears D/E, resets RF)
//   bus      : decode_stage_if.slave -- D inputs, FlushE, writeback port,
//              Rs1D/Rs2D to the hazard unit, registered E outputs.
// Optional macro RF_WRITE_BYPASS_EN (passed through to regfile_2r1w):
// same-cycle writeback is visible to the register read.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RF_RESET_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    decode_stage_if.slave bus
);
    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } de_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    ctrl_t           ctrl;
    imm_src_e        imm_src;
    logic [XLEN-1:0] rd1, rd2;
    de_t             de_d, de_q;

    assign opcode   = bus.InstrD[6:0];
    assign funct3   = bus.InstrD[14:12];
    assign bus.Rs1D = bus.InstrD[19:15];
    assign bus.Rs2D = bus.InstrD[24:20];

    regfile_2r1w #(.XLEN(XLEN), .RESET_VAL(RF_RESET_VAL)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (bus.InstrD[19:15]),
        .ra2_i (bus.InstrD[24:20]),
        .rd1_o (rd1),
        .rd2_o (rd2),
        .we_i  (bus.RegWriteW),
        .wa_i  (bus.RdW),
        .wd_i  (bus.ResultW)
    );

    // Control decode. Unknown opcodes fall through with all controls 0,
    // which behaves as a bubble in execute.
    always_comb begin
        ctrl    = '0;
        imm_src = IMM_I;
        case (opcode)
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_src    = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
            end
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_fn(funct3, bus.InstrD[30]);
            end
            OP_IALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_fn(funct3, 1'b0);
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                imm_src       = IMM_B;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_IMM;
                imm_src         = IMM_U;
            end
            default: ;
        endcase
    end

    always_comb begin
        de_d      = '0;
        de_d.ctrl = ctrl;
        de_d.rd1  = rd1;
        de_d.rd2  = rd2;
        de_d.imm  = extend_imm(bus.InstrD, imm_src);
        de_d.pc   = bus.PCD;
        de_d.pc4  = bus.PCPlus4D;
        de_d.rs1  = bus.InstrD[19:15];
        de_d.rs2  = bus.InstrD[24:20];
        de_d.rd   = bus.InstrD[11:7];
    end

    // A flush zeroes the whole slot so a squashed instruction can neither
    // write back nor redirect the PC.
    always_ff @(posedge clk) begin
        if (rst || bus.FlushE) de_q <= '0;
        else                   de_q <= de_d;
    end

    assign bus.RegWriteE   = de_q.ctrl.reg_write;
    assign bus.MemWriteE   = de_q.ctrl.mem_write;
    assign bus.JumpE       = de_q.ctrl.jump;
    assign bus.BranchE     = de_q.ctrl.branch;
    assign bus.ALUSrcE     = de_q.ctrl.alu_src;
    assign bus.ResultSrcE  = de_q.ctrl.result_src;
    assign bus.ALUControlE = de_q.ctrl.alu_ctrl;
    assign bus.RD1E        = de_q.rd1;
    assign bus.RD2E        = de_q.rd2;
    assign bus.ImmExtE     = de_q.imm;
    assign bus.PCE         = de_q.pc;
    assign bus.PCPlus4E    = de_q.pc4;
    assign bus.Rs1E        = de_q.rs1;
    assign bus.Rs2E        = de_q.rs2;
    assign bus.RdE         = de_q.rd;
endmodule
